// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    ARMED = 2'd2
  } seq_state_t;

  localparam logic [7:0] SEQ_DEF_PAT = 8'b1001_0001;

endpackage : seq_det_pkg

// File: rtl/seq_shreg.sv
// History shift register plus saturating fill counter for seq_detector.
// Clear has priority over shift; full_next is only meaningful when shift is high.
module seq_shreg #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             shift,
  input  logic             clear,
  input  logic             din,
  output logic [PAT_W-1:0] hist,
  output logic [PAT_W-1:0] hist_next,
  output logic             full_next
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign hist      = hist_q;
  assign hist_next = {hist_q[PAT_W-2:0], din};
  // A shift this cycle leaves the history full if it is already full or one short.
  assign full_next = (fill_q == FILL_MAX) || (fill_q == FILL_MAX - 1'b1);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_next;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : seq_shreg

// File: rtl/seq_detector.sv
// Serial sequence detector: masked pattern match over the last PAT_W valid bits.
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             find_out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, mask_q;
  logic             find_q, armed_q;

  logic             shift, hit, sr_clear, full_next;
  logic [PAT_W-1:0] hist_next, unused_hist;

  // A load in the same cycle discards the incoming bit.
  assign shift    = din_valid && !pat_load && (state_q != IDLE);
  assign hit      = shift && full_next && ((hist_next ^ pat_q) & mask_q) == '0;
  assign sr_clear = pat_load || (hit && !overlap);

  seq_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk       (clk),
    .rst_      (rst_),
    .shift     (shift),
    .clear     (sr_clear),
    .din       (din),
    .hist      (unused_hist),
    .hist_next (hist_next),
    .full_next (full_next)
  );

  always_comb begin
    state_d = state_q;
    if (pat_load) begin
      state_d = HUNT;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        HUNT:  if (shift && full_next && !(hit && !overlap)) state_d = ARMED;
        ARMED: if (hit && !overlap) state_d = HUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      pat_q   <= '0;
      mask_q  <= '0;
      find_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pat_load) begin
        pat_q  <= pat_in;
        mask_q <= mask_in;
      end
      find_q  <= hit;
      armed_q <= (state_d == ARMED);
    end
  end

  assign find_out = find_q;
  assign armed    = armed_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                cnt_d = '0;
    else if (hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule : seq_detector

// File: tb/tb_seq_detector.sv
// Self-checking bench: an 8-bit and a 4-bit (CNT_W=2) detector against a queue-based model.
module tb_seq_detector;
  import seq_det_pkg::*;

`ifdef SEQDET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 is PAT_W=8/CNT_W=8, index 1 is PAT_W=4/CNT_W=2.
  logic       v_valid[2], v_din[2], v_load[2], v_ov[2], v_clr[2];
  logic [7:0] v_pat[2], v_mask[2];
  logic       find_w[2], armed_w[2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int checks = 0, failures = 0;
  int pulses[2];

  seq_detector #(.PAT_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_(rst_), .din_valid(v_valid[0]), .din(v_din[0]),
    .pat_load(v_load[0]), .pat_in(v_pat[0]), .mask_in(v_mask[0]),
    .overlap(v_ov[0]), .cnt_clr(v_clr[0]),
    .find_out(find_w[0]), .armed(armed_w[0]), .match_cnt(cnt0)
  );

  seq_detector #(.PAT_W(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_(rst_), .din_valid(v_valid[1]), .din(v_din[1]),
    .pat_load(v_load[1]), .pat_in(v_pat[1][3:0]), .mask_in(v_mask[1][3:0]),
    .overlap(v_ov[1]), .cnt_clr(v_clr[1]),
    .find_out(find_w[1]), .armed(armed_w[1]), .match_cnt(cnt1)
  );

  // Reference model: a queue of bits collected since the last load or non-overlap match.
  bit         mq[2][$];
  bit         m_loaded[2];
  logic [7:0] m_pat[2], m_mask[2];
  int         m_cnt[2];
  bit         exp_find[2], exp_armed[2];

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_loaded[i]  = 1'b0;
        m_pat[i]     = '0;
        m_mask[i]    = '0;
        m_cnt[i]     = 0;
        exp_find[i]  = 1'b0;
        exp_armed[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit hit;
        int w;
        hit = 1'b0;
        w   = w_of(i);
        if (v_load[i]) begin
          m_loaded[i] = 1'b1;
          m_pat[i]    = v_pat[i];
          m_mask[i]   = v_mask[i];
          mq[i].delete();
        end else if (m_loaded[i] && v_valid[i]) begin
          mq[i].push_back(v_din[i]);
          if (mq[i].size() > w) void'(mq[i].pop_front());
          if (mq[i].size() == w) begin
            hit = 1'b1;
            for (int j = 0; j < w; j++)
              if (m_mask[i][w-1-j] && (mq[i][j] != m_pat[i][w-1-j])) hit = 1'b0;
            if (hit && !v_ov[i]) mq[i].delete();
          end
        end
        if (!CNT_EN)                          m_cnt[i] = 0;
        else if (v_clr[i])                    m_cnt[i] = 0;
        else if (hit && m_cnt[i] < cmax_of(i)) m_cnt[i] = m_cnt[i] + 1;
        exp_find[i]  = hit;
        exp_armed[i] = (mq[i].size() == w);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  // One clock: outputs compared on the falling edge, one-shot inputs then dropped.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("find%0d", i),  32'(find_w[i]),  32'(exp_find[i]));
      check($sformatf("armed%0d", i), 32'(armed_w[i]), 32'(exp_armed[i]));
      check($sformatf("cnt%0d", i),   cnt_of(i),       32'(m_cnt[i]));
      if (find_w[i]) pulses[i]++;
      v_valid[i] = 1'b0;
      v_load[i]  = 1'b0;
      v_clr[i]   = 1'b0;
    end
  endtask

  task automatic load(input int i, input logic [7:0] p, input logic [7:0] m);
    v_load[i] = 1'b1;
    v_pat[i]  = p;
    v_mask[i] = m;
    tick();
  endtask

  task automatic send(input int i, input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) begin
      v_valid[i] = 1'b1;
      v_din[i]   = b[k];
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v_valid[i] = 0; v_din[i] = 0; v_load[i] = 0; v_ov[i] = 0; v_clr[i] = 0;
      v_pat[i] = '0; v_mask[i] = '0; pulses[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_find8", 32'(find_w[0]), 0);
    check("rst_armed4", 32'(armed_w[1]), 0);
    check("rst_cnt8", 32'(cnt0), 0);
    rst_ = 1'b1;

    // IDLE ignores valid bits.
    send(0, 16'h0091, 8);
    check("idle_pulses", pulses[0], 0);

    // Default sync word on the 8-bit instance.
    load(0, SEQ_DEF_PAT, 8'hFF);
    send(0, 16'h0091, 8);
    check("sync_find", 32'(find_w[0]), 1);
    check("sync_cnt", 32'(cnt0), CNT_EN ? 32'd1 : 32'd0);

    // Overlap vs non-overlap on the 4-bit instance.
    v_ov[1] = 1'b1; pulses[1] = 0;
    load(1, 8'h0A, 8'h0F);
    send(1, 16'h00AA, 8);
    check("ovl_pulses", pulses[1], 3);
    v_ov[1] = 1'b0; pulses[1] = 0;
    load(1, 8'h0A, 8'h0F);
    send(1, 16'h00AA, 8);
    check("novl_pulses", pulses[1], 2);

    // Don't-care mask.
    pulses[1] = 0;
    load(1, 8'h09, 8'h09);
    send(1, 16'h000F, 4);
    check("mask_pulses", pulses[1], 1);
    pulses[1] = 0;
    load(1, 8'h09, 8'h0F);
    send(1, 16'h000F, 4);
    check("nomask_pulses", pulses[1], 0);

    // Valid gaps mid-pattern, then load colliding with a valid bit.
    v_ov[0] = 1'b1; pulses[0] = 0;
    load(0, SEQ_DEF_PAT, 8'hFF);
    send(0, 16'h0012, 5);
    repeat (3) tick();
    send(0, 16'h0001, 3);
    check("gap_pulses", pulses[0], 1);
    check("gap_armed", 32'(armed_w[0]), 1);
    v_valid[0] = 1'b1; v_din[0] = 1'b1;
    load(0, SEQ_DEF_PAT, 8'hFF);
    check("coll_armed", 32'(armed_w[0]), 0);
    pulses[0] = 0;
    send(0, 16'h0011, 7);
    check("coll_pulses", pulses[0], 0);

    // Saturating counter (CNT_W=2) and clear-beats-match.
    v_clr[1] = 1'b1; tick();
    v_ov[1] = 1'b1; pulses[1] = 0;
    load(1, 8'h00, 8'h00);
    send(1, 16'h00C5, 8);
    check("sat_pulses", pulses[1], 5);
    check("sat_cnt", 32'(cnt1), CNT_EN ? 32'd3 : 32'd0);
    v_clr[1] = 1'b1;
    send(1, 16'h0001, 1);
    check("clr_find", 32'(find_w[1]), 1);
    check("clr_cnt", 32'(cnt1), 0);

    // Asynchronous reset mid-sequence; the pattern is lost.
    load(0, SEQ_DEF_PAT, 8'hFF);
    send(0, 16'h0012, 5);
    check("pre_rst_armed4", 32'(armed_w[1]), 1);
    #2 rst_ = 1'b0;
    #1;
    check("arst_find4", 32'(find_w[1]), 0);
    check("arst_armed4", 32'(armed_w[1]), 0);
    check("arst_cnt8", 32'(cnt0), 0);
    @(negedge clk);
    rst_ = 1'b1;
    pulses[0] = 0;
    send(0, 16'h0091, 8);
    check("post_rst_pulses", pulses[0], 0);
    check("post_rst_armed", 32'(armed_w[0]), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        v_load[i]  = ($urandom_range(0, 39) == 0);
        v_pat[i]   = 8'($urandom);
        v_mask[i]  = 8'($urandom & $urandom & $urandom);
        v_valid[i] = ($urandom_range(0, 3) != 0);
        v_din[i]   = 1'($urandom);
        v_clr[i]   = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 15) == 0) v_ov[i] = 1'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_detector

// File: doc/seq_detector.md
# seq_detector

Parametrised serial sequence detector, the successor to the fixed 8-bit check state machine. It samples one bit per qualified clock and pulses `find_out` when the last `PAT_W` bits match a runtime-loaded pattern under a don't-care mask. It supports overlapping and non-overlapping match modes and an optional saturating match counter. It sits on serial receive paths as a sync-word and frame-marker detector.

## Interface
- `PAT_W`, default 8: pattern length in bits, at least 2.
- `CNT_W`, default 8: width of the match counter.
- `clk` input, 1: sole clock, rising edge.
- `rst_` input, 1: asynchronous, active-low reset.
- `din_valid` input, 1: qualifies `din` this cycle.
- `din` input, 1: serial data. The first bit of a sequence compares against `pat[PAT_W-1]`.
- `pat_load` input, 1: loads `pat_in` and `mask_in`.
- `pat_in` input, `PAT_W`: pattern.
- `mask_in` input, `PAT_W`: per-bit compare enable. 1 means compare; 0 means don't-care.
- `overlap` input, 1: 1 selects overlapping matches; 0 selects non-overlapping.
- `cnt_clr` input, 1: synchronous clear of `match_cnt`.
- `find_out` output, 1: one-cycle match pulse.
- `armed` output, 1: high in ARMED state.
- `match_cnt` output, `CNT_W`: saturating match count.

## Operation
- States:
  - IDLE: no pattern loaded.
  - HUNT: fewer than `PAT_W` bits collected.
  - ARMED: history full; a match check runs on each valid bit.
- Reset values:
  - state is IDLE.
  - History, fill count, pattern and mask are 0.
  - `find_out`, `armed` and `match_cnt` are 0.
- IDLE:
  - `din_valid` is ignored.
  - `pat_load` moves to HUNT.
- `pat_load` from any state:
  - Captures `pat_in` and `mask_in`.
  - Clears history and fill count, and goes to HUNT.
  - A `din` bit presented in the same cycle is discarded, so load wins.
- Each valid bit:
  - `hist <= {hist[PAT_W-2:0], din}`.
  - Fill count increments and saturates at `PAT_W`.
- Match condition: `((hist_next ^ pat) & mask) == 0` and fill count reaching `PAT_W` this cycle, or already at `PAT_W`.
- On a match:
  - `find_out` pulses.
  - If `overlap` = 0, fill count resets to 0 and the state returns to HUNT, so the next match needs `PAT_W` fresh bits.
  - If `overlap` = 1, the block stays in ARMED.
- HUNT moves to ARMED when fill reaches `PAT_W` without a non-overlap match.
- All-zero mask: the block matches every time the fill condition is met. This is legal and not an error.
- `overlap` is sampled each cycle. Changing it mid-stream affects only subsequent matches.
- `match_cnt`:
  - Increments on each match and saturates at all-ones.
  - If `cnt_clr` and a match occur in the same cycle, clear wins and the result is 0.

## Timing
- `find_out` is registered. It asserts in the cycle after the edge that samples the final matching bit and lasts exactly one cycle.
- `match_cnt` updates on the same edge that raises `find_out`.
- `armed` is registered and follows the state.
- With no `din_valid` gaps, back-to-back overlapping matches can produce `find_out` on consecutive cycles.
- `din_valid` low cycles freeze history, fill and state. They do not break a partial match.
- Reset asserted mid-sequence:
  - All registers return to reset values asynchronously.
  - The pattern is lost, and the block waits in IDLE for `pat_load`.
- Release of `rst_` is synchronised externally; the block does not re-synchronise it.

## Configuration
- `SEQDET_CNT_EN`: when defined, the match counter is implemented as specified.
- When undefined:
  - `match_cnt` is tied to 0 and `cnt_clr` is ignored.
  - Ports remain, and all other behaviour is unchanged.

## Structure
- Package `seq_det_pkg` holds:
  - the state enum typedef `seq_state_t` (IDLE, HUNT, ARMED);
  - the default sync constant `SEQ_DEF_PAT` = 8'b1001_0001.
- Sub-module `seq_shreg` holds the `PAT_W` history register and the saturating fill counter. It takes shift, clear and `din`, and provides `hist`, `hist_next` and `full_next`.
- The top level contains the FSM, the compare logic and the counter.

## Test plan
- Load with `PAT_W`=8:
  - Stimulus: `pat_in`=8'b1001_0001, mask 8'hFF, then stream 1,0,0,1,0,0,0,1 with `din_valid` held high.
  - Response: one `find_out` pulse in the cycle after the 8th bit; `match_cnt`=1.
- Overlap on a `PAT_W`=4 instance:
  - Stimulus: pattern 4'b1010, stream 10101010.
  - Response: `overlap`=1 gives pulses after bits 4, 6 and 8 (count 3); `overlap`=0 gives pulses after bits 4 and 8 (count 2).
- Mask:
  - Stimulus: pattern 4'b1001, mask 4'b1001, stream 1111.
  - Response: a match after bit 4. With mask 4'hF, the same stream gives no match.
- Valid gaps and load collision:
  - Stimulus: insert 3 idle cycles mid-pattern.
  - Response: the match still occurs after the final bit.
  - Stimulus: assert `pat_load` with `din_valid` high.
  - Response: the bit is discarded, `armed`=0 and fill restarts.
- Counter, with `SEQDET_CNT_EN` and `CNT_W`=2:
  - Stimulus: 5 matches.
  - Response: `match_cnt`=3.
  - Stimulus: `cnt_clr` coincident with a match.
  - Response: `match_cnt`=0.
- Reset:
  - Stimulus: pull `rst_` low after 5 of 8 pattern bits.
  - Response: all outputs go to 0 immediately and the state is IDLE.
  - Stimulus: stream the full pattern without reloading.
  - Response: no `find_out`.
